// File: rtl/pkt_check.sv
// Packet framing checker: measures each sop..eop packet and reports length, short/long/framing errors and totals.
// Build option PKT_SUM_EN adds a per-packet modulo-2^16 byte sum on pkt_sum.
module pkt_check #(
    parameter int MIN_LEN = 46,
    parameter int MAX_LEN = 1500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_vld,
    input  logic        din_sop,
    input  logic        din_eop,
    output logic        pkt_vld,
    output logic [10:0] pkt_len,
    output logic        err_short,
    output logic        err_long,
    output logic        err_frame,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt
`ifdef PKT_SUM_EN
    ,
    output logic [15:0] pkt_sum
`endif
);
    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);

    typedef enum logic {IDLE, DATA} state_t;

    state_t      state, state_nxt;
    logic [10:0] cnt, cnt_nxt, len_inc, rpt_len;
    logic        rpt, rpt_frame, rpt_short, rpt_long, stray;
    logic        err_frame_q, stray_q;

    assign len_inc   = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
    assign rpt_short = rpt_len < MIN_L;
    assign rpt_long  = rpt_len > MAX_L;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rpt       = 1'b0;
        rpt_len   = cnt;
        rpt_frame = 1'b0;
        stray     = 1'b0;
        if (din_vld) begin
            case (state)
                IDLE: begin
                    if (!din_sop) begin
                        stray = 1'b1;
                    end else if (din_eop) begin
                        rpt     = 1'b1;
                        rpt_len = 11'd1;
                    end else begin
                        cnt_nxt   = 11'd1;
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    case ({din_sop, din_eop})
                        2'b00: cnt_nxt = len_inc;
                        2'b01: begin
                            rpt       = 1'b1;
                            rpt_len   = len_inc;
                            state_nxt = IDLE;
                        end
                        // sop inside an open packet closes the old one as a framing error
                        2'b10: begin
                            rpt       = 1'b1;
                            rpt_frame = 1'b1;
                            cnt_nxt   = 11'd1;
                        end
                        default: begin
                            rpt       = 1'b1;
                            rpt_frame = 1'b1;
                            state_nxt = IDLE;
                        end
                    endcase
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 11'd0;
            pkt_vld     <= 1'b0;
            pkt_len     <= 11'd0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_frame_q <= 1'b0;
            stray_q     <= 1'b0;
            pkt_cnt     <= 16'd0;
            err_cnt     <= 16'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pkt_vld <= rpt;
            stray_q <= stray;
            if (rpt) begin
                pkt_len     <= rpt_len;
                err_short   <= rpt_short;
                err_long    <= rpt_long;
                err_frame_q <= rpt_frame;
                if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
            end
            if ((rpt && (rpt_short || rpt_long || rpt_frame)) || stray) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    // Stray-byte pulse overlays the held report flag for exactly one cycle
    assign err_frame = err_frame_q | stray_q;

`ifdef PKT_SUM_EN
    logic [15:0] sum, sum_nxt, rpt_sum;

    always_comb begin
        sum_nxt = sum;
        rpt_sum = sum;
        if (din_vld) begin
            if (state == IDLE) begin
                if (din_sop) begin
                    sum_nxt = {8'h00, din};
                    rpt_sum = {8'h00, din};
                end
            end else if (din_sop) begin
                sum_nxt = {8'h00, din};
            end else begin
                sum_nxt = sum + {8'h00, din};
                rpt_sum = sum + {8'h00, din};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= 16'd0;
            pkt_sum <= 16'd0;
        end else begin
            sum <= sum_nxt;
            if (rpt) pkt_sum <= rpt_sum;
        end
    end
`else
    logic unused_din;
    assign unused_din = ^din;
`endif

endmodule

// File: tb/tb_pkt_check.sv
// Bench for pkt_check: packet table plus hand sequences, reports checked against a queue of expected results.
module tb_pkt_check;
    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_vld, din_sop, din_eop;
    logic        pkt_vld;
    logic [10:0] pkt_len;
    logic        err_short, err_long, err_frame;
    logic [15:0] pkt_cnt, err_cnt;
`ifdef PKT_SUM_EN
    logic [15:0] pkt_sum;
`endif

    pkt_check #(.MIN_LEN(46), .MAX_LEN(1500)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
        .din_sop(din_sop), .din_eop(din_eop), .pkt_vld(pkt_vld),
        .pkt_len(pkt_len), .err_short(err_short), .err_long(err_long),
        .err_frame(err_frame), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
`ifdef PKT_SUM_EN
        , .pkt_sum(pkt_sum)
`endif
    );

    typedef struct {
        int          len;
        bit          s;
        bit          l;
        bit          f;
        logic [15:0] sum;
        int          cyc;
    } rpt_t;

    typedef struct {
        int nbytes;
        bit bubbles;
        bit ones;
        int exp_len;
        bit exp_short;
        bit exp_long;
    } vec_t;

    rpt_t        exp_q[$];
    rpt_t        mon_e;
    vec_t        vecs[9];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] exp_pkt_cnt = 0;
    logic [15:0] exp_err_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        din = d; din_sop = s; din_eop = e; din_vld = 1'b1;
        @(posedge clk); #1;
    endtask

    // Invalid cycle with sop/eop asserted: must be ignored
    task automatic bubble();
        din = 8'hA5; din_sop = 1'b1; din_eop = 1'b1; din_vld = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_rpt(input int len, input bit s, input bit l, input bit f, input logic [15:0] sum);
        rpt_t r;
        r.len = len; r.s = s; r.l = l; r.f = f; r.sum = sum; r.cyc = cyc;
        exp_q.push_back(r);
    endtask

    task automatic send_pkt(input int n, input bit bubbles, input bit ones,
                            input int elen, input bit es, input bit el);
        logic [15:0] sum;
        logic [7:0]  d;
        sum = 16'd0;
        for (int i = 0; i < n; i++) begin
            if (bubbles && (i % 3 == 1)) bubble();
            d = ones ? 8'hFF : 8'($urandom_range(0, 255));
            sum = sum + {8'h00, d};
            send_byte(d, i == 0, i == n - 1);
        end
        push_rpt(elen, es, el, 1'b0, sum);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pkt_vld"},   32'(pkt_vld),   32'd0);
        check({tag, "_pkt_len"},   32'(pkt_len),   32'd0);
        check({tag, "_err_short"}, 32'(err_short), 32'd0);
        check({tag, "_err_long"},  32'(err_long),  32'd0);
        check({tag, "_err_frame"}, 32'(err_frame), 32'd0);
        check({tag, "_pkt_cnt"},   32'(pkt_cnt),   32'd0);
        check({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
`ifdef PKT_SUM_EN
        check({tag, "_pkt_sum"},   32'(pkt_sum),   32'd0);
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL missing_report: no pkt_vld at cycle %0d, expected len %0d", exp_q[0].cyc, exp_q[0].len);
                void'(exp_q.pop_front());
            end
            if (pkt_vld) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_report: pkt_vld=1 len %0d at cycle %0d, expected no report", pkt_len, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (exp_pkt_cnt != 16'hFFFF) exp_pkt_cnt++;
                    if ((mon_e.s || mon_e.l || mon_e.f) && exp_err_cnt != 16'hFFFF) exp_err_cnt++;
                    check("rpt_cycle", 32'(cyc),       32'(mon_e.cyc));
                    check("pkt_len",   32'(pkt_len),   32'(mon_e.len));
                    check("err_short", 32'(err_short), 32'(mon_e.s));
                    check("err_long",  32'(err_long),  32'(mon_e.l));
                    check("err_frame", 32'(err_frame), 32'(mon_e.f));
                    check("pkt_cnt",   32'(pkt_cnt),   32'(exp_pkt_cnt));
                    check("err_cnt",   32'(err_cnt),   32'(exp_err_cnt));
`ifdef PKT_SUM_EN
                    check("pkt_sum",   32'(pkt_sum),   32'(mon_e.sum));
`endif
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] s1, s2;
        logic [7:0]  d;
        logic [15:0] err_before;

        vecs[0] = '{64,   0, 0, 64,   0, 0};
        vecs[1] = '{10,   1, 0, 10,   1, 0};
        vecs[2] = '{46,   0, 0, 46,   0, 0};
        vecs[3] = '{45,   1, 0, 45,   1, 0};
        vecs[4] = '{2100, 0, 0, 2047, 0, 1};
        vecs[5] = '{1500, 0, 0, 1500, 0, 0};
        vecs[6] = '{1501, 0, 0, 1501, 0, 1};
        vecs[7] = '{47,   1, 0, 47,   0, 0};
        vecs[8] = '{300,  0, 1, 300,  0, 0};

        din = 8'h00; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        check_zero("reset");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Three back-to-back stray bytes in IDLE
        for (int i = 0; i < 3; i++) begin
            send_byte(8'(8'h10 + i), 1'b0, 1'b0);
            exp_err_cnt++;
            @(negedge clk);
            check("stray_err_frame", 32'(err_frame), 32'd1);
            check("stray_pkt_vld",   32'(pkt_vld),   32'd0);
        end
        idle(1);
        @(negedge clk);
        check("stray_pulse_end", 32'(err_frame), 32'd0);
        check("stray_err_cnt",   32'(err_cnt),   32'd3);
        check("stray_pkt_cnt",   32'(pkt_cnt),   32'd0);

        send_byte(8'h5A, 1'b1, 1'b1);
        push_rpt(1, 1'b1, 1'b0, 1'b0, 16'h005A);
        idle(2);

        for (int v = 0; v < 9; v++) begin
            send_pkt(vecs[v].nbytes, vecs[v].bubbles, vecs[v].ones,
                     vecs[v].exp_len, vecs[v].exp_short, vecs[v].exp_long);
            if (v % 2 == 0) idle(1);
        end
        idle(2);
`ifdef PKT_SUM_EN
        check("sum_300xFF", 32'(pkt_sum), 32'h2AD4);
`endif

        // sop at byte 30 of an open packet, then 50 more bytes ending in eop
        err_before = err_cnt;
        s1 = 16'd0;
        for (int i = 1; i <= 29; i++) begin
            d = 8'($urandom_range(0, 255));
            s1 = s1 + {8'h00, d};
            send_byte(d, i == 1, 1'b0);
        end
        d = 8'($urandom_range(0, 255));
        send_byte(d, 1'b1, 1'b0);
        push_rpt(29, 1'b1, 1'b0, 1'b1, s1);
        s2 = {8'h00, d};
        for (int i = 1; i <= 50; i++) begin
            d = 8'($urandom_range(0, 255));
            s2 = s2 + {8'h00, d};
            send_byte(d, 1'b0, i == 50);
        end
        push_rpt(51, 1'b0, 1'b0, 1'b0, s2);
        idle(3);
        @(negedge clk);
        check("abort_err_cnt_delta", 32'(err_cnt - err_before), 32'd1);
        check("hold_pkt_len",        32'(pkt_len),              32'd51);
        check("hold_pkt_vld_low",    32'(pkt_vld),              32'd0);

        // sop&eop inside an open packet: old one reported, 1-byte one dropped
        s1 = 16'd0;
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i * 7);
            s1 = s1 + {8'h00, d};
            send_byte(d, i == 1, 1'b0);
        end
        send_byte(8'h99, 1'b1, 1'b1);
        push_rpt(5, 1'b1, 1'b0, 1'b1, s1);
        idle(1);
        send_pkt(50, 1'b0, 1'b0, 50, 1'b0, 1'b0);
        idle(2);

        // Reset in the middle of a packet
        for (int i = 1; i <= 20; i++) send_byte(8'(i), i == 1, 1'b0);
        rst_n = 1'b0;
        #2;
        check_zero("midreset");
        exp_q.delete();
        exp_pkt_cnt = 16'd0;
        exp_err_cnt = 16'd0;
        din_vld = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send_pkt(50, 1'b0, 1'b0, 50, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        check("post_reset_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("post_reset_err_cnt", 32'(err_cnt), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
